// File: rtl/de_write_queue_if.sv
// Bundles the drawing-unit and framestore handshakes of the write queue.
// Latency: none, wiring only.
// Backpressure: de_ack/mem_ack pulses carry all flow control; no storage here.
interface de_write_queue_if #(
  parameter int ADDR_W = 18
);
  // drawing-unit side
  logic              de_req;
  logic              de_ack;
  logic [ADDR_W-1:0] de_addr;
  logic [3:0]        de_nbyte;
  logic              de_rnw;
  logic [31:0]       de_w_data;
  logic [31:0]       de_r_data;
  // framestore side
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_nbyte;
  logic              mem_rnw;
  logic [31:0]       mem_w_data;
  logic [31:0]       mem_r_data;

  // Queue view: accepts drawing-unit commands, issues framestore commands.
  modport slave (
    input  de_req, de_addr, de_nbyte, de_rnw, de_w_data,
    output de_ack, de_r_data,
    output mem_req, mem_addr, mem_nbyte, mem_rnw, mem_w_data,
    input  mem_ack, mem_r_data
  );

  // Environment view: drawing unit plus framestore model.
  modport master (
    output de_req, de_addr, de_nbyte, de_rnw, de_w_data,
    input  de_ack, de_r_data,
    input  mem_req, mem_addr, mem_nbyte, mem_rnw, mem_w_data,
    output mem_ack, mem_r_data
  );
endinterface

// File: rtl/de_write_queue.sv
// Posted-write queue between drawing unit and framestore; reads wait for the queue to drain.
// Latency: write de_ack 1 cycle after de_req sampled, mem_req 1 cycle later; reads ack in RETURN.
// Backpressure: de_ack withheld while full (unless a tail merge is possible); build option DE_WRITE_COMBINE_EN merges same-address writes.
module de_write_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  de_write_queue_if.slave bus,
  output logic            empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        nbyte;
    logic [31:0]       data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RETURN
  } state_t;

  entry_t           q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;

  entry_t new_entry;
  logic   req_new;
  logic   is_discard;
  logic   full;
  logic   q_empty;
  logic   merge_ok;
  logic   wr_acc;
  logic   rd_acc;
  logic   push;
  logic   pop;

  // Incoming command and its acceptance decision.
  always_comb begin
    new_entry.addr  = bus.de_addr;
    new_entry.nbyte = bus.de_nbyte;
    new_entry.data  = bus.de_w_data;
  end

  // A request is new only outside the ack cycle, so a held req is taken once.
  assign req_new    = bus.de_req && !bus.de_ack;
  assign is_discard = (bus.de_nbyte == 4'b1111);
  assign full       = (count == CNT_W'(DEPTH));
  assign q_empty    = (count == '0);

`ifdef DE_WRITE_COMBINE_EN
  logic [PTR_W-1:0] tail_ptr;
  entry_t           merged;

  assign tail_ptr = wr_ptr - PTR_W'(1);

  // The head is either on mem_* or about to be loaded there, so merging is
  // only safe when the tail is a different entry (two or more queued).
  assign merge_ok = (count >= CNT_W'(2)) && (q[tail_ptr].addr == bus.de_addr);

  // Enabled bytes of the new write overwrite the tail; enables accumulate.
  always_comb begin
    merged       = q[tail_ptr];
    merged.nbyte = q[tail_ptr].nbyte & bus.de_nbyte;
    for (int i = 0; i < 4; i++) begin
      if (!bus.de_nbyte[i]) begin
        merged.data[8*i +: 8] = bus.de_w_data[8*i +: 8];
      end
    end
  end
`else
  assign merge_ok = 1'b0;
`endif

  assign wr_acc = req_new && !bus.de_rnw && (is_discard || !full || merge_ok);
  // Reads never overtake queued or in-flight writes.
  assign rd_acc = req_new && bus.de_rnw && q_empty && (state == IDLE);
  assign push   = wr_acc && !is_discard && !merge_ok;
  assign pop    = (state == WRITE) && bus.mem_ack;

  assign empty  = q_empty && (state == IDLE);

  // Queue storage; the entry on mem_* is a registered copy, never rewritten here.
  always_ff @(posedge clk) begin
    if (push) begin
      q[wr_ptr] <= new_entry;
    end
`ifdef DE_WRITE_COMBINE_EN
    else if (wr_acc && !is_discard && merge_ok) begin
      q[tail_ptr] <= merged;
    end
`endif
  end

  // Pointers wrap naturally at a power-of-two depth; push+pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Memory engine with registered handshake and command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.de_ack     <= 1'b0;
      bus.de_r_data  <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_rnw    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_nbyte  <= 4'b1111;
      bus.mem_w_data <= '0;
    end else begin
      bus.de_ack <= wr_acc;
      case (state)
        IDLE: begin
          if (rd_acc) begin
            state         <= READ;
            bus.mem_req   <= 1'b1;
            bus.mem_rnw   <= 1'b1;
            bus.mem_addr  <= bus.de_addr;
            bus.mem_nbyte <= 4'b0000;
          end else if (!q_empty) begin
            state          <= WRITE;
            bus.mem_req    <= 1'b1;
            bus.mem_rnw    <= 1'b0;
            bus.mem_addr   <= q[rd_ptr].addr;
            bus.mem_nbyte  <= q[rd_ptr].nbyte;
            bus.mem_w_data <= q[rd_ptr].data;
          end
        end
        WRITE: begin
          // Returning through IDLE guarantees a low cycle on mem_req.
          if (bus.mem_ack) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
          end
        end
        READ: begin
          if (bus.mem_ack) begin
            state         <= RETURN;
            bus.mem_req   <= 1'b0;
            bus.de_r_data <= bus.mem_r_data;
            bus.de_ack    <= 1'b1;
          end
        end
        RETURN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_de_write_queue.sv
// Directed bench for de_write_queue: drawing-unit driver plus framestore responder.
// Checks reset, latency, full-queue stall, combine option, read ordering, discard, mid-access reset.
module tb_de_write_queue;

  logic clk = 1'b0;
  logic rst_n;
  logic empty;

  de_write_queue_if #(.ADDR_W(18)) bus ();

  de_write_queue #(.DEPTH(4), .ADDR_W(18)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .empty (empty)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Framestore model controls and transaction log.
  bit          stall     = 1'b1;
  int          ack_delay = 1;
  logic [31:0] rd_value  = '0;
  int          wait_cnt  = 0;
  int          gap_err   = 0;
  int          log_n     = 0;
  logic [17:0] log_addr  [0:31];
  logic [3:0]  log_nbyte [0:31];
  logic        log_rnw   [0:31];
  logic [31:0] log_data  [0:31];

  // Responder: mem_ack is a single-cycle pulse after ack_delay cycles of mem_req.
  initial begin
    bus.mem_ack    = 1'b0;
    bus.mem_r_data = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
        if (bus.mem_req) gap_err++;
      end else if (bus.mem_req) begin
        wait_cnt++;
        if (!stall && wait_cnt >= ack_delay) begin
          bus.mem_ack    = 1'b1;
          bus.mem_r_data = rd_value;
          if (log_n < 32) begin
            log_addr[log_n]  = bus.mem_addr;
            log_nbyte[log_n] = bus.mem_nbyte;
            log_rnw[log_n]   = bus.mem_rnw;
            log_data[log_n]  = bus.mem_w_data;
          end
          log_n++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic de_drive(input logic rnw, input logic [17:0] a, input logic [3:0] nb, input logic [31:0] d);
    bus.de_req    = 1'b1;
    bus.de_rnw    = rnw;
    bus.de_addr   = a;
    bus.de_nbyte  = nb;
    bus.de_w_data = d;
  endtask

  task automatic de_wait(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.de_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic de_write(input logic [17:0] a, input logic [3:0] nb, input logic [31:0] d, output bit ok);
    de_drive(1'b0, a, nb, d);
    de_wait(10, ok);
    bus.de_req = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (empty && !bus.mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL %s drain: empty never seen, got %0b expected 1", name, empty);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.de_req = 1'b0; bus.de_rnw = 1'b0; bus.de_addr = '0; bus.de_nbyte = 4'hF; bus.de_w_data = '0;
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.de_ack, bus.mem_req, bus.mem_rnw, bus.mem_nbyte, empty} !== 8'b0001_1111) begin
      n_fail++;
      $display("FAIL reset_ctrl: ack/req/rnw/nbyte/empty got %b expected 00011111",
               {bus.de_ack, bus.mem_req, bus.mem_rnw, bus.mem_nbyte, empty});
    end
    n_tests++;
    if ({bus.mem_addr, bus.mem_w_data, bus.de_r_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h expected 0", bus.mem_addr, bus.mem_w_data, bus.de_r_data);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    bit ok;
    log_n = 0; stall = 1'b0; ack_delay = 2;
    de_drive(1'b0, 18'h000A0, 4'b1110, 32'h07070707);
    @(negedge clk);
    n_tests++;
    if ({bus.de_ack, bus.mem_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_ack_cycle: ack,mem_req got %b expected 10", {bus.de_ack, bus.mem_req});
    end
    bus.de_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.de_ack, bus.mem_req, bus.mem_rnw, empty} !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_mem_req: ack,req,rnw,empty got %b expected 0100", {bus.de_ack, bus.mem_req, bus.mem_rnw, empty});
    end
    n_tests++;
    if ({bus.mem_addr, bus.mem_nbyte, bus.mem_w_data} !== {18'h000A0, 4'b1110, 32'h07070707}) begin
      n_fail++;
      $display("FAIL single_fields: addr %h nbyte %b data %h expected 000a0 1110 07070707",
               bus.mem_addr, bus.mem_nbyte, bus.mem_w_data);
    end
    wait_empty("single");
    n_tests++;
    if (log_n !== 1 || log_addr[0] !== 18'h000A0 || log_nbyte[0] !== 4'b1110 || log_data[0] !== 32'h07070707) begin
      n_fail++;
      $display("FAIL single_log: n %0d addr %h nbyte %b data %h expected 1 000a0 1110 07070707",
               log_n, log_addr[0], log_nbyte[0], log_data[0]);
    end
    ok = 1'b1;
  endtask

  task automatic test_full();
    bit ok;
    int acks;
    log_n = 0; stall = 1'b1; ack_delay = 1; gap_err = 0; acks = 0;
    for (int i = 0; i < 4; i++) begin
      de_write(18'h00010 + 18'(i), 4'b0000, 32'h100 + 32'(i), ok);
      if (ok) acks++;
    end
    n_tests++;
    if (acks !== 4) begin
      n_fail++;
      $display("FAIL full_first4: acks %0d expected 4", acks);
    end
    de_drive(1'b0, 18'h00014, 4'b0000, 32'h104);
    de_wait(6, ok);
    n_tests++;
    if (ok !== 1'b0) begin
      n_fail++;
      $display("FAIL full_withheld: fifth ack %0b expected 0", ok);
    end
    stall = 1'b0;
    de_wait(10, ok);
    bus.de_req = 1'b0;
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL full_release: fifth ack %0b expected 1", ok);
    end
    wait_empty("full");
    n_tests++;
    if (log_n !== 5) begin
      n_fail++;
      $display("FAIL full_count: mem writes %0d expected 5", log_n);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (log_addr[i] !== 18'h00010 + 18'(i) || log_data[i] !== 32'h100 + 32'(i) || log_rnw[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL full_order%0d: addr %h data %h rnw %b expected %h %h 0",
                 i, log_addr[i], log_data[i], log_rnw[i], 18'h00010 + 18'(i), 32'h100 + 32'(i));
      end
    end
    n_tests++;
    if (gap_err !== 0) begin
      n_fail++;
      $display("FAIL full_req_gap: back-to-back mem_req %0d expected 0", gap_err);
    end
  endtask

  task automatic test_combine();
    bit ok;
    log_n = 0; stall = 1'b1; ack_delay = 1;
    de_write(18'h00050, 4'b0000, 32'hAAAAAAAA, ok);
    de_write(18'h00100, 4'b1110, 32'h00000011, ok);
    de_write(18'h00100, 4'b1101, 32'h00002200, ok);
    repeat (2) @(negedge clk);
    stall = 1'b0;
    wait_empty("combine");
`ifdef DE_WRITE_COMBINE_EN
    n_tests++;
    if (log_n !== 2 || log_addr[1] !== 18'h00100 || log_nbyte[1] !== 4'b1100 || log_data[1][15:0] !== 16'h2211) begin
      n_fail++;
      $display("FAIL combine_merged: n %0d addr %h nbyte %b data %h expected 2 00100 1100 ....2211",
               log_n, log_addr[1], log_nbyte[1], log_data[1]);
    end
`else
    n_tests++;
    if (log_n !== 3 || log_addr[1] !== 18'h00100 || log_nbyte[1] !== 4'b1110 || log_data[1] !== 32'h00000011) begin
      n_fail++;
      $display("FAIL combine_sep1: n %0d addr %h nbyte %b data %h expected 3 00100 1110 00000011",
               log_n, log_addr[1], log_nbyte[1], log_data[1]);
    end
    n_tests++;
    if (log_addr[2] !== 18'h00100 || log_nbyte[2] !== 4'b1101 || log_data[2] !== 32'h00002200) begin
      n_fail++;
      $display("FAIL combine_sep2: addr %h nbyte %b data %h expected 00100 1101 00002200",
               log_addr[2], log_nbyte[2], log_data[2]);
    end
`endif
  endtask

  task automatic test_read();
    bit ok;
    log_n = 0; stall = 1'b1; ack_delay = 1; rd_value = 32'hDEADBEEF;
    de_write(18'h00300, 4'b0000, 32'h33333333, ok);
    de_write(18'h00301, 4'b0000, 32'h44444444, ok);
    de_drive(1'b1, 18'h00200, 4'b0000, 32'h0);
    de_wait(4, ok);
    n_tests++;
    if (ok !== 1'b0) begin
      n_fail++;
      $display("FAIL read_overtake: read ack %0b expected 0 while writes pending", ok);
    end
    stall = 1'b0;
    de_wait(40, ok);
    n_tests++;
    if (ok !== 1'b1 || bus.de_r_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL read_data: ack %0b rdata %h expected 1 deadbeef", ok, bus.de_r_data);
    end
    bus.de_req = 1'b0;
    bus.de_rnw = 1'b0;
    wait_empty("read");
    n_tests++;
    if (log_n !== 3 || log_addr[0] !== 18'h00300 || log_addr[1] !== 18'h00301 ||
        log_addr[2] !== 18'h00200 || log_rnw[2] !== 1'b1 || log_nbyte[2] !== 4'b0000) begin
      n_fail++;
      $display("FAIL read_order: n %0d addrs %h %h %h rnw %b nbyte %b expected 3 00300 00301 00200 1 0000",
               log_n, log_addr[0], log_addr[1], log_addr[2], log_rnw[2], log_nbyte[2]);
    end
  endtask

  task automatic test_discard();
    bit ok;
    int req_seen;
    log_n = 0; stall = 1'b0; req_seen = 0;
    de_write(18'h00777, 4'b1111, 32'h55555555, ok);
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_req || !empty) req_seen++;
      @(negedge clk);
    end
    n_tests++;
    if (ok !== 1'b1 || req_seen !== 0 || log_n !== 0) begin
      n_fail++;
      $display("FAIL discard: ack %0b busy cycles %0d mem ops %0d expected 1 0 0", ok, req_seen, log_n);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    log_n = 0; stall = 1'b0; ack_delay = 1;
    de_drive(1'b0, 18'h00400, 4'b0000, 32'h12345678);
    de_wait(10, ok);
    @(negedge clk);
    n_tests++;
    if (bus.de_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL held_req_ack: ack %b expected 0 after ack cycle", bus.de_ack);
    end
    bus.de_req = 1'b0;
    wait_empty("held");
    n_tests++;
    if (log_n !== 1 || log_addr[0] !== 18'h00400) begin
      n_fail++;
      $display("FAIL held_req_once: mem writes %0d addr %h expected 1 00400", log_n, log_addr[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int req_seen;
    log_n = 0; stall = 1'b1; ack_delay = 1; req_seen = 0;
    de_write(18'h00500, 4'b0000, 32'h5, ok);
    de_write(18'h00501, 4'b0000, 32'h6, ok);
    de_write(18'h00502, 4'b0000, 32'h7, ok);
    n_tests++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: mem_req %b expected 1", bus.mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_req, empty, bus.mem_nbyte} !== 6'b01_1111) begin
      n_fail++;
      $display("FAIL rstmid_now: req,empty,nbyte got %b expected 011111", {bus.mem_req, empty, bus.mem_nbyte});
    end
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_req) req_seen++;
    end
    n_tests++;
    if (req_seen !== 0 || log_n !== 0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_after: mem_req cycles %0d mem ops %0d empty %b expected 0 0 1", req_seen, log_n, empty);
    end
    // first edge after release must already accept
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    de_drive(1'b0, 18'h00600, 4'b0000, 32'h66);
    @(negedge clk);
    n_tests++;
    if (bus.de_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL first_accept: ack %b expected 1", bus.de_ack);
    end
    bus.de_req = 1'b0;
    wait_empty("first_accept");
    n_tests++;
    if (log_n !== 1 || log_addr[0] !== 18'h00600) begin
      n_fail++;
      $display("FAIL first_accept_write: mem ops %0d addr %h expected 1 00600", log_n, log_addr[0]);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single_write();
    test_full();
    test_combine();
    test_read();
    test_discard();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a stimulus loop never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule

// File: doc/de_write_queue.md
DE_WRITE_QUEUE -- requirements
Module: de_write_queue

Interface
REQ-001 Parameter: DEPTH, 4, write-queue entries (power of two, 2..16).
REQ-002 Parameter: ADDR_W, 18, word-address width on both ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 de_req  input  1  drawing-unit request; held high until de_ack seen.
REQ-006 de_ack  output  1  one-cycle accept pulse to drawing unit.
REQ-007 de_addr  input  ADDR_W  32-bit-word address (pixel address >> 2).
REQ-008 de_nbyte  input  4  active-low byte enables; bit i low = write byte i.
REQ-009 de_rnw  input  1  1 = read, 0 = write.
REQ-010 de_w_data  input  32  write data.
REQ-011 de_r_data  output  32  read data, valid in the de_ack cycle of a read.
REQ-012 mem_req / mem_ack  output / input  1 / 1  framestore request; mem_ack is a one-cycle pulse.
REQ-013 mem_addr, mem_nbyte, mem_rnw, mem_w_data  output  ADDR_W, 4, 1, 32  framestore command, stable while mem_req high.
REQ-014 mem_r_data  input  32  read data, valid in the mem_ack cycle.
REQ-015 empty  output  1  high when queue holds no entry and no memory access is in flight.

Function
REQ-016 Accept condition: de_req && !de_ack && (write: queue not full or merge possible; read: queue empty and engine IDLE); de_ack high exactly the following cycle.
REQ-017 de_ack never asserted two consecutive cycles; a request held across the ack cycle is accepted once only.
REQ-018 Write accepted -> {addr, nbyte, data} pushed at tail; queue is in-order FIFO.
REQ-019 Full queue (DEPTH entries, no merge possible) -> de_ack withheld; de_req stays pending without loss or corruption.
REQ-020 Memory engine states: IDLE, WRITE, READ, RETURN.
REQ-021 IDLE, queue non-empty -> WRITE next cycle: mem_req=1, mem_rnw=0, head entry on mem_* outputs.
REQ-022 WRITE, mem_ack -> head popped, mem_req=0 next cycle, return to IDLE; mem_req low at least one cycle between accesses.
REQ-023 Read accepted in IDLE -> READ: mem_req=1, mem_rnw=1, mem_addr=de_addr, mem_nbyte=4'b0000.
REQ-024 READ, mem_ack -> mem_r_data captured, RETURN; de_r_data driven and de_ack pulsed in RETURN, then IDLE (read de_ack replaces REQ-016 pulse timing).
REQ-025 Reads never overtake writes: read accepted only with queue empty and engine IDLE.
REQ-026 Minimum write latency, empty queue: de_req sampled at edge k -> de_ack in cycle k+1 -> mem_req high in cycle k+2.
REQ-027 Push and pop in same cycle -> occupancy unchanged; pointers wrap modulo DEPTH.
REQ-028 Entry being presented on mem_* is never modified.
REQ-029 de_nbyte=4'b1111 write -> acknowledged, discarded, nothing queued.

Reset
REQ-030 rst_n low -> immediately: de_ack=0, mem_req=0, mem_rnw=0, mem_nbyte=4'b1111, mem_addr=0, mem_w_data=0, de_r_data=0, queue emptied, engine IDLE, empty=1.
REQ-031 Reset mid-access -> all queued and in-flight commands discarded; no mem_req after release until a new accept.
REQ-032 First accept possible on the first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro DE_WRITE_COMBINE_EN.
REQ-034 Defined: write whose address equals the tail entry's, tail not the in-flight head -> merged into tail (bytes with nbyte bit low overwrite, nbyte = old AND new), no new entry; allowed when full.
REQ-035 Undefined: every non-discarded write occupies its own entry; no merging logic present.

Verification
REQ-036 Single write addr 0x00A0, nbyte 1110, data 0x07070707, mem_ack 2 cycles after mem_req -> one mem write, identical fields, de_ack one cycle, empty=1 after.
REQ-037 mem_ack held off, 5 writes to distinct addresses, DEPTH=4 -> 4 acks, 5th de_ack withheld until first mem_ack; 5 mem writes in order.
REQ-038 With DE_WRITE_COMBINE_EN, mem stalled on entry A, then writes 0x0100/1110/0x11 and 0x0100/1101/0x22 -> single mem write 0x0100, nbyte 1100, data bytes[1:0]=0x22,0x11.
REQ-039 Same stimulus, macro undefined -> two separate mem writes, original nbyte each.
REQ-040 Two queued writes then read 0x0200, mem_r_data 0xDEADBEEF -> read issued after both writes; de_r_data=0xDEADBEEF in de_ack cycle.
REQ-041 rst_n pulsed low while mem_req high with 3 queued -> mem_req drops immediately, no further mem_req, empty=1.
